// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder for the cache line read/write
// request interface, backed by a word-addressed array with programmable
// read and write latencies. One transaction is outstanding at a time.
module cache_mem_responder #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned WR_LAT = 1
) (
    input  logic         clk_g,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    localparam int unsigned DEPTH        = 1 << MEM_AW;
    localparam logic [2:0]  TYPE_LINE    = 3'b100;
    localparam logic [3:0]  RD_WAIT_INIT = 4'((RD_LAT >= 2) ? (RD_LAT - 2) : 0);
    localparam logic [3:0]  WR_BUSY_INIT = 4'((WR_LAT >= 1) ? (WR_LAT - 1) : 0);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
    typedef enum logic       {W_IDLE, W_BUSY}          wstate_t;

    logic [31:0]       r_mem [DEPTH];

    rstate_t           r_rstate, w_rstate_nxt;
    logic [MEM_AW-1:0] r_rbase, w_rbase_nxt;
    logic [1:0]        r_rlast, w_rlast_nxt;
    logic [1:0]        r_rbeat, w_rbeat_nxt;
    logic [3:0]        r_rlat, w_rlat_nxt;
    logic              w_load_beat;
    logic              r_ret_valid, r_ret_last;
    logic [31:0]       r_ret_data;

    wstate_t           r_wstate, w_wstate_nxt;
    logic [3:0]        r_wcnt, w_wcnt_nxt;
    logic              w_commit;
    logic [MEM_AW-1:0] r_widx;
    logic              r_wline;
    logic [3:0]        r_wstrb;
    logic [127:0]      r_wdata;

    logic              w_rd_acc, w_wr_acc, w_rd_line, w_wr_line;
    logic [MEM_AW-1:0] w_rd_base, w_wr_base, w_rd_idx;
    logic [31:0]       w_rd_word;
    logic              w_unused;

    // Handshakes and address decode; address bits outside the array alias.
    assign wr_rdy    = !reset && (r_wstate == W_IDLE) && (r_rstate == R_IDLE);
    assign rd_rdy    = !reset && (r_wstate == W_IDLE) && (r_rstate == R_IDLE) && !wr_req;
    assign w_rd_acc  = rd_req && rd_rdy;
    assign w_wr_acc  = wr_req && wr_rdy;
    assign w_rd_line = (rd_type == TYPE_LINE);
    assign w_wr_line = (wr_type == TYPE_LINE);
    assign w_rd_base = w_rd_line ? {rd_addr[MEM_AW+1:4], 2'b00} : rd_addr[MEM_AW+1:2];
    assign w_wr_base = w_wr_line ? {wr_addr[MEM_AW+1:4], 2'b00} : wr_addr[MEM_AW+1:2];
    assign w_unused  = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0], wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    // Word fetched for the beat that will be presented next cycle.
    assign w_rd_idx  = w_rbase_nxt + MEM_AW'(w_rbeat_nxt);
    assign w_rd_word = r_mem[w_rd_idx];

    assign ret_valid = r_ret_valid;
    assign ret_last  = r_ret_last;
    assign ret_data  = r_ret_data;

    // Read FSM next-state: accept, latency wait, then one beat per cycle.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rbase_nxt  = r_rbase;
        w_rlast_nxt  = r_rlast;
        w_rbeat_nxt  = r_rbeat;
        w_rlat_nxt   = r_rlat;
        w_load_beat  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_rd_acc) begin
                    w_rbase_nxt = w_rd_base;
                    w_rlast_nxt = w_rd_line ? 2'd3 : 2'd0;
                    w_rbeat_nxt = 2'd0;
                    if (RD_LAT <= 1) begin
                        w_rstate_nxt = R_BURST;
                        w_load_beat  = 1'b1;
                    end else begin
                        w_rlat_nxt   = RD_WAIT_INIT;
                        w_rstate_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_rlat == 4'd0) begin
                    w_rstate_nxt = R_BURST;
                    w_rbeat_nxt  = 2'd0;
                    w_load_beat  = 1'b1;
                end else begin
                    w_rlat_nxt = r_rlat - 4'd1;
                end
            end
            R_BURST: begin
                if (r_rbeat == r_rlast) begin
                    w_rstate_nxt = R_IDLE;
                end else begin
                    w_rbeat_nxt = r_rbeat + 2'd1;
                    w_load_beat = 1'b1;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Write FSM next-state: busy for WR_LAT cycles, commit on the last one.
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wcnt_nxt   = r_wcnt;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_wr_acc) begin
                    w_wstate_nxt = W_BUSY;
                    w_wcnt_nxt   = WR_BUSY_INIT;
                end
            end
            W_BUSY: begin
                if (r_wcnt == 4'd0) begin
                    w_wstate_nxt = W_IDLE;
                    w_commit     = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // State, counters and registered return beat.
    always_ff @(posedge clk_g) begin
        if (reset) begin
            r_rstate    <= R_IDLE;
            r_wstate    <= W_IDLE;
            r_rbase     <= '0;
            r_rlast     <= 2'd0;
            r_rbeat     <= 2'd0;
            r_rlat      <= 4'd0;
            r_wcnt      <= 4'd0;
            r_ret_valid <= 1'b0;
            r_ret_last  <= 1'b0;
            r_ret_data  <= 32'd0;
        end else begin
            r_rstate    <= w_rstate_nxt;
            r_wstate    <= w_wstate_nxt;
            r_rbase     <= w_rbase_nxt;
            r_rlast     <= w_rlast_nxt;
            r_rbeat     <= w_rbeat_nxt;
            r_rlat      <= w_rlat_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_ret_valid <= w_load_beat;
            r_ret_last  <= w_load_beat && (w_rbeat_nxt == w_rlast_nxt);
            r_ret_data  <= w_load_beat ? w_rd_word : 32'd0;
        end
    end

    // Capture the write payload at accept.
    always_ff @(posedge clk_g) begin
        if (w_wr_acc) begin
            r_widx  <= w_wr_base;
            r_wline <= w_wr_line;
            r_wstrb <= wr_wstrb;
            r_wdata <= wr_data;
        end
    end

    // Memory commit; a reset during the busy phase drops the write.
    always_ff @(posedge clk_g) begin
        if (w_commit && !reset) begin
            if (r_wline) begin
                for (int k = 0; k < 4; k++) begin
                    r_mem[{r_widx[MEM_AW-1:2], 2'(k)}] <= r_wdata[32*k +: 32];
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (r_wstrb[b]) begin
                        r_mem[r_widx][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed vector table,
// multi-cycle corner sequences and randomized traffic against a word-array model.
module tb_cache_mem_responder;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 1;
    localparam int unsigned DEPTH  = 1 << MEM_AW;

    logic         clk_g = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  mdl [DEPTH];

    typedef struct {
        bit           is_wr;
        logic [2:0]   typ;
        logic [31:0]  addr;
        logic [3:0]   strb;
        logic [127:0] wdata;
        int           nbeats;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [10];
    logic [127:0] tb_d;
    bit           tb_ok;
    bit           tb_line;
    int           tb_t;
    logic [2:0]   tb_typ;
    logic [31:0]  tb_a;
    logic [3:0]   tb_strb;

    cache_mem_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk_g    (clk_g),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_type  (rd_type),
        .rd_addr  (rd_addr),
        .rd_rdy   (rd_rdy),
        .ret_valid(ret_valid),
        .ret_last (ret_last),
        .ret_data (ret_data),
        .wr_req   (wr_req),
        .wr_type  (wr_type),
        .wr_addr  (wr_addr),
        .wr_wstrb (wr_wstrb),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy)
    );

    always #5 clk_g = ~clk_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: memory is a flat array of words; addresses wrap modulo its size.
    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic int lbase(input logic [31:0] a);
        return int'(((a >> 4) % (DEPTH / 4)) * 4);
    endfunction

    task automatic mdl_write(input bit line, input logic [31:0] a, input logic [3:0] strb,
                             input logic [127:0] data);
        if (line) begin
            for (int k = 0; k < 4; k++) mdl[lbase(a) + k] = data[32*k +: 32];
        end else begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[widx(a)][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    function automatic logic [127:0] mdl_read(input bit line, input logic [31:0] a);
        logic [127:0] r;
        r = '0;
        if (line) begin
            for (int k = 0; k < 4; k++) r[32*k +: 32] = mdl[lbase(a) + k];
        end else begin
            r[31:0] = mdl[widx(a)];
        end
        return r;
    endfunction

    // Raise rd_req at a cycle boundary; returns #1 after the accepting edge.
    task automatic accept_read(input logic [2:0] typ, input logic [31:0] a, input bit keep,
                               output bit ok);
        @(posedge clk_g); #1;
        rd_type = typ; rd_addr = a; rd_req = 1'b1; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_g);
            if (rd_rdy) begin ok = 1'b1; break; end
            @(posedge clk_g); #1;
        end
        if (ok) begin
            @(posedge clk_g); #1;
            if (!keep) rd_req = 1'b0;
        end else begin
            chk("rd_accept_timeout", 32'd0, 32'd1);
            rd_req = 1'b0;
        end
    endtask

    task automatic accept_write(input logic [2:0] typ, input logic [31:0] a, input logic [3:0] strb,
                                input logic [127:0] data, output bit ok);
        @(posedge clk_g); #1;
        wr_type = typ; wr_addr = a; wr_wstrb = strb; wr_data = data; wr_req = 1'b1; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_g);
            if (wr_rdy) begin ok = 1'b1; break; end
            @(posedge clk_g); #1;
        end
        if (ok) begin
            @(posedge clk_g); #1;
        end else begin
            chk("wr_accept_timeout", 32'd0, 32'd1);
        end
        wr_req = 1'b0;
    endtask

    // Called #1 after a write accept: both readies low for WR_LAT cycles.
    task automatic write_busy(input string name);
        for (int i = 0; i < int'(WR_LAT); i++) begin
            @(negedge clk_g);
            chk({name, "_busy_wr_rdy"}, 32'(wr_rdy), 32'd0);
            chk({name, "_busy_rd_rdy"}, 32'(rd_rdy), 32'd0);
            @(posedge clk_g); #1;
        end
        @(negedge clk_g);
        chk({name, "_done_wr_rdy"}, 32'(wr_rdy), 32'd1);
    endtask

    // Called #1 after a read accept: silent wait, n contiguous beats, ready back.
    task automatic expect_burst(input string name, input int n, input logic [127:0] exp);
        for (int i = 1; i < int'(RD_LAT); i++) begin
            @(negedge clk_g);
            chk({name, "_wait_valid"}, 32'(ret_valid), 32'd0);
            chk({name, "_wait_data"}, ret_data, 32'd0);
            chk({name, "_wait_rd_rdy"}, 32'(rd_rdy), 32'd0);
            @(posedge clk_g); #1;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk_g);
            chk({name, $sformatf("_b%0d_valid", k)}, 32'(ret_valid), 32'd1);
            chk({name, $sformatf("_b%0d_data", k)}, ret_data, exp[32*k +: 32]);
            chk({name, $sformatf("_b%0d_last", k)}, 32'(ret_last), 32'(k == n - 1));
            chk({name, $sformatf("_b%0d_rd_rdy", k)}, 32'(rd_rdy), 32'd0);
            @(posedge clk_g); #1;
        end
        @(negedge clk_g);
        chk({name, "_end_valid"}, 32'(ret_valid), 32'd0);
        chk({name, "_end_data"}, ret_data, 32'd0);
        chk({name, "_end_rd_rdy"}, 32'(rd_rdy), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'b100, 32'h0000_0040, 4'h0, 128'h33333333_22222222_11111111_00000000, 0, 128'h0};
        vecs[1] = '{1'b0, 3'b100, 32'h0000_0048, 4'h0, 128'h0, 4, 128'h33333333_22222222_11111111_00000000};
        vecs[2] = '{1'b1, 3'b010, 32'h0000_0044, 4'b0011, 128'hDEADBEEF_DEADBEEF_DEADBEEF_AAAABBBB, 0, 128'h0};
        vecs[3] = '{1'b0, 3'b010, 32'h0000_0044, 4'h0, 128'h0, 1, 128'h1111BBBB};
        vecs[4] = '{1'b0, 3'b100, 32'h1000_0040, 4'h0, 128'h0, 4, 128'h33333333_22222222_1111BBBB_00000000};
        vecs[5] = '{1'b0, 3'b000, 32'h0000_004B, 4'h0, 128'h0, 1, 128'h22222222};
        vecs[6] = '{1'b1, 3'b100, 32'h0000_004C, 4'h0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 128'h0};
        vecs[7] = '{1'b0, 3'b111, 32'h8000_004C, 4'h0, 128'h0, 1, 128'hDDDDDDDD};
        vecs[8] = '{1'b1, 3'b001, 32'h0000_0042, 4'b1100, 128'h12345678, 0, 128'h0};
        vecs[9] = '{1'b0, 3'b100, 32'h0000_0040, 4'h0, 128'h0, 4, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_1234AAAA};

        reset = 1'b1; rd_req = 1'b0; rd_type = 3'b0; rd_addr = 32'h0;
        wr_req = 1'b0; wr_type = 3'b0; wr_addr = 32'h0; wr_wstrb = 4'h0; wr_data = '0;

        // Reset state.
        repeat (2) @(posedge clk_g);
        @(negedge clk_g);
        chk("rst_ret_valid", 32'(ret_valid), 32'd0);
        chk("rst_ret_last", 32'(ret_last), 32'd0);
        chk("rst_ret_data", ret_data, 32'd0);
        chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("rst_wr_rdy", 32'(wr_rdy), 32'd0);
        @(posedge clk_g); #1;
        reset = 1'b0;
        @(negedge clk_g);
        chk("post_rst_rd_rdy", 32'(rd_rdy), 32'd1);
        chk("post_rst_wr_rdy", 32'(wr_rdy), 32'd1);

        // Fill the whole array so every later read has a defined reference.
        for (int i = 0; i < int'(DEPTH / 4); i++) begin
            tb_d = {$urandom, $urandom, $urandom, $urandom};
            accept_write(3'b100, 32'(i * 16), 4'h0, tb_d, tb_ok);
            if (tb_ok) begin
                write_busy("init");
                mdl_write(1'b1, 32'(i * 16), 4'h0, tb_d);
            end
        end

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) begin
                accept_write(vecs[i].typ, vecs[i].addr, vecs[i].strb, vecs[i].wdata, tb_ok);
                if (tb_ok) begin
                    write_busy($sformatf("vec%0d", i));
                    mdl_write(vecs[i].typ == 3'b100, vecs[i].addr, vecs[i].strb, vecs[i].wdata);
                end
            end else begin
                accept_read(vecs[i].typ, vecs[i].addr, 1'b0, tb_ok);
                if (tb_ok) expect_burst($sformatf("vec%0d", i), vecs[i].nbeats, vecs[i].exp);
            end
        end

        // Simultaneous read and write to the same line: write goes first.
        @(posedge clk_g); #1;
        tb_d = 128'h44444444_77777777_66666666_55555555;
        rd_type = 3'b100; rd_addr = 32'h80; rd_req = 1'b1;
        wr_type = 3'b100; wr_addr = 32'h84; wr_wstrb = 4'h0; wr_data = tb_d; wr_req = 1'b1;
        @(negedge clk_g);
        chk("sim_wr_rdy", 32'(wr_rdy), 32'd1);
        chk("sim_rd_rdy", 32'(rd_rdy), 32'd0);
        @(posedge clk_g); #1;
        wr_req = 1'b0;
        mdl_write(1'b1, 32'h84, 4'h0, tb_d);
        for (int i = 0; i < int'(WR_LAT); i++) begin
            @(negedge clk_g);
            chk("sim_busy_rd_rdy", 32'(rd_rdy), 32'd0);
            @(posedge clk_g); #1;
        end
        @(negedge clk_g);
        chk("sim_after_rd_rdy", 32'(rd_rdy), 32'd1);
        @(posedge clk_g); #1;
        rd_req = 1'b0;
        expect_burst("sim_rd", 4, tb_d);

        // Back-to-back reads with rd_req held high.
        tb_d = mdl_read(1'b1, 32'h40);
        accept_read(3'b100, 32'h40, 1'b1, tb_ok);
        if (tb_ok) begin
            expect_burst("b2b_0", 4, tb_d);
            @(posedge clk_g); #1;
            rd_req = 1'b0;
            expect_burst("b2b_1", 4, tb_d);
        end

        // Reset on the third beat of a line read.
        tb_d = mdl_read(1'b1, 32'h40);
        accept_read(3'b100, 32'h40, 1'b0, tb_ok);
        if (tb_ok) begin
            repeat (RD_LAT + 1) @(posedge clk_g);
            #1;
            reset = 1'b1;
            @(negedge clk_g);
            chk("rstb_beat2_valid", 32'(ret_valid), 32'd1);
            chk("rstb_beat2_data", ret_data, tb_d[95:64]);
            @(posedge clk_g); #1;
            @(negedge clk_g);
            chk("rstb_valid", 32'(ret_valid), 32'd0);
            chk("rstb_last", 32'(ret_last), 32'd0);
            chk("rstb_data", ret_data, 32'd0);
            @(posedge clk_g); #1;
            reset = 1'b0;
            @(negedge clk_g);
            chk("rstb_rd_rdy", 32'(rd_rdy), 32'd1);
            chk("rstb_wr_rdy", 32'(wr_rdy), 32'd1);
        end

        // Reset during the write busy phase drops the write.
        tb_d = ~mdl_read(1'b1, 32'h40);
        accept_write(3'b100, 32'h40, 4'h0, tb_d, tb_ok);
        if (tb_ok) begin
            reset = 1'b1;
            @(negedge clk_g);
            chk("rstw_wr_rdy", 32'(wr_rdy), 32'd0);
            @(posedge clk_g); #1;
            reset = 1'b0;
            @(negedge clk_g);
            chk("rstw_wr_rdy_after", 32'(wr_rdy), 32'd1);
            chk("rstw_rd_rdy_after", 32'(rd_rdy), 32'd1);
        end
        accept_read(3'b100, 32'h40, 1'b0, tb_ok);
        if (tb_ok) expect_burst("rstw_rd", 4, mdl_read(1'b1, 32'h40));

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            tb_line = 1'($urandom_range(0, 1));
            tb_t = int'($urandom_range(0, 6));
            if (tb_t >= 4) tb_t++;
            tb_typ = tb_line ? 3'b100 : 3'(tb_t);
            tb_a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                tb_d = {$urandom, $urandom, $urandom, $urandom};
                tb_strb = 4'($urandom);
                accept_write(tb_typ, tb_a, tb_strb, tb_d, tb_ok);
                if (tb_ok) begin
                    write_busy("rnd_wr");
                    mdl_write(tb_line, tb_a, tb_strb, tb_d);
                end
            end else begin
                tb_d = mdl_read(tb_line, tb_a);
                accept_read(tb_typ, tb_a, 1'b0, tb_ok);
                if (tb_ok) expect_burst("rnd_rd", tb_line ? 4 : 1, tb_d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
